modbus_tx_framer: RTL

- Modbus RTU transmit framer; sits directly upstream of the byte-level UART transmitter.
- Accepts a frame's payload bytes on a valid/ready stream, hands each byte to the UART, and computes CRC-16/MODBUS on the fly.
- After the last payload byte, appends the CRC (low byte first), then enforces the 3.5-character inter-frame silence before accepting the next frame.

---
 rtl/modbus_pkg.sv | 36 +++
 rtl/modbus_crc16.sv | 24 ++
 rtl/modbus_tx_framer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU framer: FSM/phase encodings, CRC-16/MODBUS
// constants and the combinational one-byte CRC step.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_NEXT      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_DATA   = 2'd0,
    PH_CRC_LO = 2'd1,
    PH_CRC_HI = 2'd2
  } phase_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // 3.5 characters x 10 bits x 347 clocks per bit
  localparam int T35_CLKS_DEFAULT = 12145;

  // Reflected CRC-16 step: eight LSB-first shift/xor rounds in a single cycle.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Registered CRC-16/MODBUS accumulator; i_Init with i_Update folds the byte into a fresh
// CRC_INIT, i_Init alone restarts. Reused by the receive-side frame checker.
module modbus_crc16
  import modbus_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Init,
  input  logic        i_Update,
  input  logic [7:0]  i_Byte,
  output logic [15:0] o_Crc
);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Crc <= CRC_INIT;
    end else if (i_Update) begin
      o_Crc <= crc16_update(i_Init ? CRC_INIT : o_Crc, i_Byte);
    end else if (i_Init) begin
      o_Crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/modbus_tx_framer.sv
// Modbus RTU transmit framer: forwards payload bytes to the UART, appends CRC (low byte
// first) when MODBUS_TX_CRC_EN is defined, then holds T35_CLKS of line silence.
module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter int T35_CLKS = T35_CLKS_DEFAULT
)
(
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Byte_Valid,
  input  logic [7:0] i_Byte,
  input  logic       i_Byte_Last,
  output logic       o_Byte_Ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Busy,
  output logic       o_Frame_Done
);

  localparam logic [15:0] GAP_LAST = 16'(T35_CLKS - 1);

  state_t      state;
  phase_t      phase;
  logic [7:0]  data_q;
  logic        last_q;
  logic        done_q;
  logic [15:0] gap_cnt;
  logic        transfer;
  logic        done_rise;
  logic        gap_expire;
  logic [7:0]  tx_sel;

  // Payload handshake: a byte moves on a rising clock where i_Byte_Valid and o_Byte_Ready
  // are both high; upstream holds i_Byte/i_Byte_Last steady while valid is high and ready low.
  assign transfer   = i_Byte_Valid & o_Byte_Ready;
  assign done_rise  = i_Tx_Done & ~done_q;
  assign gap_expire = (state == ST_GAP) && (gap_cnt == GAP_LAST);

`ifdef MODBUS_TX_CRC_EN
  logic [15:0] crc;
  logic        crc_init;

  // First byte of a frame seeds from CRC_INIT; gap expiry leaves the register clean.
  assign crc_init = ((state == ST_IDLE) && transfer) || gap_expire;

  modbus_crc16 u_crc (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Init   (crc_init),
    .i_Update (transfer),
    .i_Byte   (i_Byte),
    .o_Crc    (crc)
  );

  always_comb begin
    tx_sel = data_q;
    case (phase)
      PH_CRC_LO: tx_sel = crc[7:0];
      PH_CRC_HI: tx_sel = crc[15:8];
      default:   tx_sel = data_q;
    endcase
  end
`else
  assign tx_sel = data_q;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= ST_GAP;
      phase        <= PH_DATA;
      gap_cnt      <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      o_Byte_Ready <= 1'b0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= '0;
      o_Frame_Done <= 1'b0;
      o_Busy       <= 1'b1;
    end else begin
      done_q       <= i_Tx_Done;
      o_Frame_Done <= 1'b0;
      case (state)
        ST_IDLE, ST_NEXT: begin
          if (transfer) begin
            data_q       <= i_Byte;
            last_q       <= i_Byte_Last;
            phase        <= PH_DATA;
            o_Byte_Ready <= 1'b0;
            o_Busy       <= 1'b1;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_Tx_Byte <= tx_sel;
          // A lingering done from the previous character also holds off the next DV.
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_Tx_DV <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (i_Tx_Active) begin
            o_Tx_DV <= 1'b0;
            state   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (done_rise) begin
            case (phase)
              PH_DATA: begin
                if (!last_q) begin
                  o_Byte_Ready <= 1'b1;
                  o_Busy       <= 1'b0;
                  state        <= ST_NEXT;
                end else begin
`ifdef MODBUS_TX_CRC_EN
                  phase <= PH_CRC_LO;
                  state <= ST_LOAD;
`else
                  gap_cnt <= '0;
                  state   <= ST_GAP;
`endif
                end
              end
`ifdef MODBUS_TX_CRC_EN
              PH_CRC_LO: begin
                phase <= PH_CRC_HI;
                state <= ST_LOAD;
              end
`endif
              default: begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            endcase
          end
        end
        ST_GAP: begin
          if (gap_expire) begin
            gap_cnt      <= '0;
            o_Frame_Done <= 1'b1;
            o_Byte_Ready <= 1'b1;
            o_Busy       <= 1'b0;
            phase        <= PH_DATA;
            state        <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          gap_cnt      <= '0;
          o_Byte_Ready <= 1'b0;
          o_Busy       <= 1'b1;
          state        <= ST_GAP;
        end
      endcase
    end
  end

endmodule
